// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt + rvalid.
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        jump_flag_ex,
    input  logic [31:0] jump_address_ex,
    output logic [31:0] instruction,
    output logic [31:0] instruction_address,
    output logic        pre_jump_flag_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_req;
    logic [31:0] r_insn;
    logic [31:0] r_iaddr;
    logic        r_dlv;
    logic [31:0] w_tgt;

    assign w_tgt               = jump_address_ex & ~32'h3;
    assign imem_req            = r_req;
    assign imem_addr           = r_pc & ~32'h3;
    assign instruction         = r_insn;
    assign instruction_address = r_iaddr;
    assign pre_jump_flag_id    = jump_flag_ex;

    // Fetch FSM: sequences requests, accepts or drops responses, redirects PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_insn  <= NOP_INSN;
            r_iaddr <= 32'h0;
            r_dlv   <= 1'b0;
        end else begin
            r_insn <= NOP_INSN;
            r_dlv  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (jump_flag_ex) r_pc <= w_tgt;
                    r_state <= REQ;
                    r_req   <= 1'b1;
                end
                REQ: begin
                    if (jump_flag_ex) begin
                        r_pc <= w_tgt;
                        if (imem_gnt) begin
                            r_state <= DISCARD;
                            r_req   <= 1'b0;
                        end
                    end else if (imem_gnt) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (jump_flag_ex) begin
                        r_pc <= w_tgt;
                        if (imem_rvalid) begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= DISCARD;
                        end
                    end else if (imem_rvalid) begin
                        r_insn  <= imem_rdata;
                        r_iaddr <= r_pc;
                        r_pc    <= r_pc + 32'd4;
                        r_dlv   <= 1'b1;
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (jump_flag_ex) r_pc <= w_tgt;
                    if (imem_rvalid) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    assign fetch_count  = r_fetch_cnt;
    assign bubble_count = r_bubble_cnt;

    // Count delivered instructions versus NOP cycles seen by decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= 32'h0;
            r_bubble_cnt <= 32'h0;
        end else if (r_dlv) begin
            r_fetch_cnt  <= r_fetch_cnt + 32'd1;
        end else begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch.
// Perf counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        jump_flag_ex = 1'b0;
    logic [31:0] jump_address_ex = 32'h0;
    logic [31:0] instruction;
    logic [31:0] instruction_address;
    logic        pre_jump_flag_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    instruction_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_gnt            (imem_gnt),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .jump_flag_ex        (jump_flag_ex),
        .jump_address_ex     (jump_address_ex),
        .instruction         (instruction),
        .instruction_address (instruction_address),
        .pre_jump_flag_id    (pre_jump_flag_id)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count         (fetch_count),
        .bubble_count        (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state: architectural PC and one outstanding request.
    logic [31:0] mpc = 32'h0;
    logic        outst = 1'b0;
    logic        killed = 1'b0;
    logic [31:0] oaddr = 32'h0;
    int          cnt = 0;
    logic [63:0] q[$];
    logic [31:0] last_addr = 32'h0;
    int          n_cyc = 0;
    int          n_dlv = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    // Instruction memory contents; never equal to the NOP encoding.
    function automatic logic [31:0] mem(logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return ((a * 32'h9E37_79B1) ^ 32'h0123_4567) | 32'h8000_0000;
    endfunction

    task automatic do_reset(input bit spur, input bit jmp,
                            input logic [31:0] tgt);
        @(posedge clk);
        #1;
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        jump_flag_ex = 1'b0;
        q.delete();
        outst = 1'b0;
        killed = 1'b0;
        last_addr = 32'h0;
        n_cyc = 0;
        n_dlv = 0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_insn", instruction, NOP);
        chk("rst_iaddr", instruction_address, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_rvalid = spur;
        imem_rdata = 32'hDEAD_BEEF;
        jump_flag_ex = jmp;
        jump_address_ex = tgt;
        mpc = jmp ? (tgt & ~32'h3) : 32'h0;
    endtask

    task automatic step(input bit jmp, input logic [31:0] tgt,
                        input bit gok, input int lat);
        logic rv;
        logic gnt;
        @(posedge clk);
        #1;
        chk("req", {31'h0, imem_req}, {31'h0, !outst});
        if (!outst) chk("addr", imem_addr, mpc);
        rv = 1'b0;
        if (outst) begin
            cnt--;
            rv = (cnt == 0);
        end
        if (outst && jmp) killed = 1'b1;
        gnt = imem_req && gok && !outst;
        imem_gnt = gnt;
        imem_rvalid = rv;
        imem_rdata = rv ? (killed ? 32'hDEAD_BEEF : mem(oaddr)) : $urandom;
        jump_flag_ex = jmp;
        jump_address_ex = tgt;
        if (rv) begin
            if (!killed) begin
                q.push_back({mem(oaddr), oaddr});
                mpc = oaddr + 32'd4;
            end
            outst = 1'b0;
        end
        if (gnt) begin
            outst = 1'b1;
            oaddr = mpc;
            killed = jmp;
            cnt = lat;
        end
        if (jmp) mpc = tgt & ~32'h3;
    endtask

    task automatic rnd_step();
        logic [31:0] t;
        case ($urandom % 3)
            0: t = $urandom & 32'hFFF;
            1: t = 32'hFFFF_FFF0 | ($urandom % 16);
            default: t = $urandom;
        endcase
        step(($urandom % 12) == 0, t, ($urandom % 10) < 7,
             $urandom_range(1, 3));
    endtask

    // Monitor: compare every presented instruction against the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            chk("pre_jump", {31'h0, pre_jump_flag_id}, {31'h0, jump_flag_ex});
`ifdef IF_PERF_CNT_EN
            chk("fetch_count", fetch_count, n_dlv);
            chk("bubble_count", bubble_count, n_cyc - n_dlv);
`endif
            n_cyc++;
            if (instruction != NOP) begin
                n_dlv++;
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_insn: got %h at %h expected none",
                             instruction, instruction_address);
                end else begin
                    n_pass++;
                    e = q.pop_front();
                    chk("insn", instruction, e[63:32]);
                    chk("insn_addr", instruction_address, e[31:0]);
                    last_addr = e[31:0];
                end
            end else begin
                chk("hold_addr", instruction_address, last_addr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b0, 1'b0, 32'h0);
        // First fetch, then grant withheld, then jump while waiting.
        repeat (3) step(1'b0, 32'h0, 1'b1, 1);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1);
        step(1'b0, 32'h0, 1'b1, 3);
        step(1'b1, 32'h100, 1'b1, 1);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1);
        // Fetch at the top of the address space wraps to zero.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1);
        repeat (3000) rnd_step();
        // Reset mid-request, stray response and jump in the first cycle.
        step(1'b0, 32'h0, 1'b1, 3);
        do_reset(1'b1, 1'b1, 32'h203);
        repeat (300) rnd_step();
        for (int i = 0; i < 10 && outst; i++) step(1'b0, 32'h0, 1'b0, 1);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1);
        @(negedge clk);
        #1;
        chk("queue_empty", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
